// File: rtl/cdb_bus_controller_if.sv
// CDB controller bus: producer request/result lanes and the broadcast CDB.
// master = the controller, slave = producers and CDB consumers.
interface cdb_bus_controller_if #(
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4,
    parameter int PRODUCERS     = 2,
    parameter int RS_ARB_STATES = 6
);
    localparam int RS_W = (RS_ARB_STATES > 1) ? $clog2(RS_ARB_STATES) : 1;

    logic [PRODUCERS-1:0]               prod_request;
    logic [PRODUCERS*DATA_WIDTH-1:0]    prod_data;
    logic [PRODUCERS*CDB_TAG_WIDTH-1:0] prod_tag;
    logic [PRODUCERS-1:0]               prod_accepted;
    logic                               flush;
    logic                               cdb_valid;
    logic [CDB_TAG_WIDTH-1:0]           cdb_tag;
    logic [DATA_WIDTH-1:0]              cdb_data;
    logic [RS_W-1:0]                    rs_arbiter_state;

    modport master (
        input  prod_request, prod_data, prod_tag, flush,
        output prod_accepted, cdb_valid, cdb_tag, cdb_data,
        output rs_arbiter_state
    );

    modport slave (
        output prod_request, prod_data, prod_tag, flush,
        input  prod_accepted, cdb_valid, cdb_tag, cdb_data,
        input  rs_arbiter_state
    );
endinterface

// File: rtl/cdb_bus_controller.sv
// Round-robin CDB arbiter with a registered broadcast stage and RS rotation.
// Optional CDB_BUSY_COUNT_EN adds a saturating busy-cycle counter port.
module cdb_bus_controller #(
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4,
    parameter int PRODUCERS     = 2,
    parameter int RS_ARB_STATES = 6
) (
    input logic clk,
    input logic rst_n,
    cdb_bus_controller_if.master bus
`ifdef CDB_BUSY_COUNT_EN
    ,
    output logic [15:0] cdb_busy_count
`endif
);
    localparam int PTR_W = (PRODUCERS > 1) ? $clog2(PRODUCERS) : 1;
    localparam int RS_W  = (RS_ARB_STATES > 1) ? $clog2(RS_ARB_STATES) : 1;

    logic [PTR_W-1:0]         ptr_q;
    logic [PTR_W-1:0]         gidx;
    logic                     found;
    logic [PRODUCERS-1:0]     grant;
    logic                     valid_q;
    logic [CDB_TAG_WIDTH-1:0] tag_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [RS_W-1:0]          rs_q;
    int                       idx;

    // Scan from ptr with wraparound; first requester wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        if (rst_n && !bus.flush) begin
            for (int k = 0; k < PRODUCERS; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= PRODUCERS) idx = idx - PRODUCERS;
                if (!found && bus.prod_request[idx]) begin
                    found = 1'b1;
                    gidx  = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) grant[gidx] = 1'b1;
    end

    assign bus.prod_accepted    = grant;
    assign bus.cdb_valid        = valid_q;
    assign bus.cdb_tag          = tag_q;
    assign bus.cdb_data         = data_q;
    assign bus.rs_arbiter_state = rs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            rs_q    <= '0;
        end else if (found) begin
            valid_q <= 1'b1;
            tag_q   <= bus.prod_tag[int'(gidx)*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
            data_q  <= bus.prod_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            ptr_q   <= (gidx == PTR_W'(PRODUCERS-1)) ? '0 : gidx + 1'b1;
            rs_q    <= (rs_q == RS_W'(RS_ARB_STATES-1)) ? '0 : rs_q + 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

`ifdef CDB_BUSY_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_busy_count <= '0;
        end else if (valid_q && !bus.flush && cdb_busy_count != 16'hFFFF) begin
            cdb_busy_count <= cdb_busy_count + 16'd1;
        end
    end
`endif
endmodule
